// File: rtl/calc_div_seq_if.sv
// calc_div_seq_if: operand/result bundle between the calculator sequencer and
// the restoring divider.
// Ports: master drives start/A/B and observes the status and results; slave is the divider.
interface calc_div_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             neg;
  logic             div0;
  logic             ovf;

  modport master (
    output start, A, B,
    input  busy, done, Q, R, neg, div0, ovf
  );

  modport slave (
    input  start, A, B,
    output busy, done, Q, R, neg, div0, ovf
  );
endinterface

// File: rtl/calc_div_seq.sv
// calc_div_seq: multi-cycle restoring divider, one quotient bit per clock.
// Ports: clk, rst (sync, active-high), bus (slave: start/A/B in; busy/done/Q/R/neg/div0/ovf out).
// Latency WIDTH+2 cycles from start to done; start is ignored while busy, accepted in the done cycle.
module calc_div_seq #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b1
) (
  input logic           clk,
  input logic           rst,
  calc_div_seq_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] b_raw;
  logic             sa;
  logic             sb;
  logic [WIDTH:0]   bm;   // |B|, one extra bit so |most-negative| is exact
  logic [WIDTH-1:0] qs;   // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH:0]   rem;  // partial remainder

  logic             sa_in;
  logic             sb_in;
  logic [WIDTH:0]   a_mag_in;
  logic [WIDTH:0]   b_mag_in;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] qmag;
  logic [WIDTH-1:0] rmag;
  logic             q_neg;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  always_comb begin
    sa_in    = SIGNED & bus.A[WIDTH-1];
    sb_in    = SIGNED & bus.B[WIDTH-1];
    a_mag_in = {sa_in, bus.A};
    b_mag_in = {sb_in, bus.B};
    // Negate after sign extension to WIDTH+1 bits so -2^(WIDTH-1) maps to +2^(WIDTH-1).
    if (sa_in) a_mag_in = -a_mag_in;
    if (sb_in) b_mag_in = -b_mag_in;

    shifted = {rem[WIDTH-1:0], qs[WIDTH-1]};
    diff    = {1'b0, shifted} - {1'b0, bm};

    qmag  = qs;
    rmag  = rem[WIDTH-1:0];
    q_neg = sa ^ sb;
    q_fix = q_neg ? -qmag : qmag;
    // Truncation toward zero: remainder follows the dividend's sign.
    r_fix = sa ? -rmag : rmag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      a_raw    <= '0;
      b_raw    <= '0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      bm       <= '0;
      qs       <= '0;
      rem      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.Q    <= '0;
      bus.R    <= '0;
      bus.neg  <= 1'b0;
      bus.div0 <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_raw    <= bus.A;
            b_raw    <= bus.B;
            sa       <= sa_in;
            sb       <= sb_in;
            // |A| always fits WIDTH unsigned bits, so the top bit is dropped.
            qs       <= a_mag_in[WIDTH-1:0];
            bm       <= b_mag_in;
            rem      <= '0;
            cnt      <= CW'(WIDTH - 1);
            bus.busy <= 1'b1;
            state    <= CALC;
          end else begin
            state <= IDLE;
          end
        end

        CALC: begin
          if (!diff[WIDTH+1]) begin
            rem <= diff[WIDTH:0];
            qs  <= {qs[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted;
            qs  <= {qs[WIDTH-2:0], 1'b0};
          end
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end

        FIX: begin
          if (b_raw == '0) begin
            bus.Q    <= '1;
            bus.R    <= a_raw;
            bus.neg  <= 1'b0;
            bus.div0 <= 1'b1;
            bus.ovf  <= 1'b0;
          end else begin
            bus.Q    <= q_fix;
            bus.R    <= r_fix;
            // A zero quotient is never reported negative (e.g. -1/10).
            bus.neg  <= q_neg && (qmag != '0);
            bus.div0 <= 1'b0;
            // Only -2^(WIDTH-1) / -1 cannot be represented; Q wraps to most-negative.
            bus.ovf  <= SIGNED && (a_raw == MOST_NEG) && (b_raw == '1);
          end
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          state    <= DONE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_div_seq.sv
module tb_calc_div_seq;

  logic clk;
  logic rst;
  int   npass;
  int   ntot;

  calc_div_seq_if #(.WIDTH(8))  bus8 ();
  calc_div_seq_if #(.WIDTH(8))  busu ();
  calc_div_seq_if #(.WIDTH(16)) bus16 ();

  calc_div_seq #(.WIDTH(8),  .SIGNED(1'b1)) dut   (.clk(clk), .rst(rst), .bus(bus8));
  calc_div_seq #(.WIDTH(8),  .SIGNED(1'b0)) dut_u (.clk(clk), .rst(rst), .bus(busu));
  calc_div_seq #(.WIDTH(16), .SIGNED(1'b1)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       neg;
    logic       div0;
    logic       ovf;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Issue one operation on the 8-bit signed unit, return cycles from start to done.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, output int lat, output bit busy_bad);
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.A     = a;
    bus8.B     = b;
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.A     = 8'h00;
    bus8.B     = 8'h00;
    lat        = 1;
    busy_bad   = 1'b0;
    while (!bus8.done && lat < 40) begin
      if (!bus8.busy) busy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int  lat;
    int  n;
    bit  bb;
    bit  saw_done;

    npass = 0;
    ntot  = 0;

    vecs[0]  = '{8'd1,   8'd10,  8'h00, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'hFF,  8'd10,  8'h00, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{8'h64,  8'hF9,  8'hF2, 8'h02, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{8'd5,   8'd0,   8'hFF, 8'h05, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{8'd23,  8'd4,   8'h05, 8'h03, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{8'hF9,  8'd2,   8'hFD, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{8'h7F,  8'h80,  8'h00, 8'h7F, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{8'h80,  8'd7,   8'hEE, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{8'h80,  8'd1,   8'h80, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{8'hF6,  8'd0,   8'hFF, 8'hF6, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    bus8.start  = 1'b0; bus8.A  = '0; bus8.B  = '0;
    busu.start  = 1'b0; busu.A  = '0; busu.B  = '0;
    bus16.start = 1'b0; bus16.A = '0; bus16.B = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("reset busy", {31'd0, bus8.busy}, 32'd0);
    chk("reset done", {31'd0, bus8.done}, 32'd0);
    chk("reset Q/R", {16'd0, bus8.Q, bus8.R}, 32'd0);
    chk("reset flags", {29'd0, bus8.neg, bus8.div0, bus8.ovf}, 32'd0);

    // Table-driven single operations.
    for (int i = 0; i < 13; i++) begin
      op8(vecs[i].a, vecs[i].b, lat, bb);
      chk($sformatf("v%0d latency", i), lat, 32'd10);
      chk($sformatf("v%0d busy during calc", i), {31'd0, bb}, 32'd0);
      chk($sformatf("v%0d busy at done", i), {31'd0, bus8.busy}, 32'd0);
      chk($sformatf("v%0d Q", i), {24'd0, bus8.Q}, {24'd0, vecs[i].q});
      chk($sformatf("v%0d R", i), {24'd0, bus8.R}, {24'd0, vecs[i].r});
      chk($sformatf("v%0d neg", i), {31'd0, bus8.neg}, {31'd0, vecs[i].neg});
      chk($sformatf("v%0d div0", i), {31'd0, bus8.div0}, {31'd0, vecs[i].div0});
      chk($sformatf("v%0d ovf", i), {31'd0, bus8.ovf}, {31'd0, vecs[i].ovf});
    end

    // Outputs hold after done until the next FIX.
    repeat (3) @(negedge clk);
    chk("hold done low", {31'd0, bus8.done}, 32'd0);
    chk("hold Q/R", {16'd0, bus8.Q, bus8.R}, {16'd0, 8'hFF, 8'hF6});

    // Back-to-back with start held high; operands change right after acceptance.
    @(negedge clk);
    bus8.start = 1'b1; bus8.A = 8'd100; bus8.B = 8'd7;
    @(negedge clk);
    bus8.A = 8'd23; bus8.B = 8'd4;
    n = 1;
    while (!bus8.done && n < 40) begin @(negedge clk); n++; end
    chk("b2b first latency", n, 32'd10);
    chk("b2b first Q/R", {16'd0, bus8.Q, bus8.R}, {16'd0, 8'd14, 8'd2});
    @(negedge clk);
    bus8.start = 1'b0;
    n = 1;
    while (!bus8.done && n < 40) begin @(negedge clk); n++; end
    chk("b2b spacing", n, 32'd10);
    chk("b2b second Q/R", {16'd0, bus8.Q, bus8.R}, {16'd0, 8'd5, 8'd3});

    // A start pulse mid-CALC must be ignored.
    @(negedge clk);
    bus8.start = 1'b1; bus8.A = 8'd100; bus8.B = 8'd7;
    @(negedge clk);
    bus8.start = 1'b0;
    n = 1;
    repeat (2) begin @(negedge clk); n++; end
    bus8.start = 1'b1; bus8.A = 8'd1; bus8.B = 8'd1;
    @(negedge clk); n++;
    bus8.start = 1'b0;
    while (!bus8.done && n < 40) begin @(negedge clk); n++; end
    chk("ignored start latency", n, 32'd10);
    chk("ignored start Q/R", {16'd0, bus8.Q, bus8.R}, {16'd0, 8'd14, 8'd2});

    // Reset four cycles into an operation.
    @(negedge clk);
    bus8.start = 1'b1; bus8.A = 8'd100; bus8.B = 8'd7;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid-op reset busy/done", {30'd0, bus8.busy, bus8.done}, 32'd0);
    chk("mid-op reset outputs", {13'd0, bus8.Q, bus8.R, bus8.neg, bus8.div0, bus8.ovf}, 32'd0);
    saw_done = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (bus8.done || bus8.busy) saw_done = 1'b1;
    end
    chk("no done after reset", {31'd0, saw_done}, 32'd0);
    op8(8'd100, 8'd7, lat, bb);
    chk("post-reset latency", lat, 32'd10);
    chk("post-reset Q/R", {16'd0, bus8.Q, bus8.R}, {16'd0, 8'd14, 8'd2});

    // Unsigned 8-bit unit: 200 / 3.
    @(negedge clk);
    busu.start = 1'b1; busu.A = 8'd200; busu.B = 8'd3;
    @(negedge clk);
    busu.start = 1'b0;
    n = 1;
    while (!busu.done && n < 40) begin @(negedge clk); n++; end
    chk("unsigned latency", n, 32'd10);
    chk("unsigned Q/R", {16'd0, busu.Q, busu.R}, {16'd0, 8'd66, 8'd2});
    chk("unsigned flags", {29'd0, busu.neg, busu.div0, busu.ovf}, 32'd0);

    // Signed 16-bit unit: -30000 / 7 = -4285 r -5.
    @(negedge clk);
    bus16.start = 1'b1; bus16.A = 16'h8AD0; bus16.B = 16'd7;
    @(negedge clk);
    bus16.start = 1'b0;
    n = 1;
    while (!bus16.done && n < 60) begin @(negedge clk); n++; end
    chk("w16 latency", n, 32'd18);
    chk("w16 Q/R", {bus16.Q, bus16.R}, {16'hEF43, 16'hFFFB});
    chk("w16 flags", {29'd0, bus16.neg, bus16.div0, bus16.ovf}, {29'd0, 3'b100});

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/calc_div_seq.md
# calc_div_seq

Parametrised multi-cycle restoring divider for the calculator datapath. It is the sequential successor to the combinational divider. It accepts a dividend/divisor pair on a start pulse and iterates one quotient bit per clock. It reports quotient, remainder, sign, divide-by-zero and overflow with a one-cycle done pulse. It sits between operand joining (num_join) and result splitting (num_split), and supports both signed and unsigned modes at any width.

## Interface

Parameters:
- WIDTH, 8, operand/result width in bits (≥2)
- SIGNED, 1, 1 = two's-complement operands, 0 = unsigned

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only while busy=0
- A  in  WIDTH  dividend
- B  in  WIDTH  divisor
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse, results valid
- Q  out  WIDTH  quotient, two's complement when SIGNED=1
- R  out  WIDTH  remainder, two's complement when SIGNED=1
- neg  out  1  true quotient is negative (nonzero); for num_split display
- div0  out  1  divisor was zero
- ovf  out  1  quotient overflow (SIGNED=1, A=most-negative, B=-1)

## Operation

- FSM states: IDLE, CALC, FIX, DONE.
- **IDLE / DONE:**
  - busy=0.
  - If start=1: latch A, B and their signs.
  - Form magnitudes |A|, |B| in WIDTH+1 bits, so the most-negative value is exact.
  - Clear the partial remainder, load the iteration counter with WIDTH-1, then go to CALC.
  - Otherwise DONE→IDLE, and IDLE holds.
- **CALC** (exactly WIDTH cycles):
  - Shift the remainder left, bringing in the next dividend MSB.
  - Trial-subtract |B|. If the result is ≥0, keep it and set the quotient bit to 1; else restore and set it to 0.
  - The counter decrements; leave for FIX when the counter = 0.
- **FIX** (1 cycle):
  - Apply signs. Q is negated if sign(A)≠sign(B); R takes the sign of A (truncation toward zero).
  - Register Q, R, neg, div0 and ovf, then go to DONE.
- **DONE** (1 cycle): done=1, then go to IDLE unless start is accepted again.
- **Divide-by-zero** (B=0 at start):
  - Still traverses CALC/FIX, so latency stays constant.
  - FIX forces Q=all-ones, R=A, div0=1, neg=0, ovf=0.
- **Overflow:** SIGNED=1, A=1000…0, B=all-ones.
  - Q=1000…0 (wrapped), R=0, ovf=1, neg=0.
- **neg:** 1 only when SIGNED=1, signs differ, and the quotient magnitude ≠0, so -1/10 gives neg=0.
- **SIGNED=0:** magnitudes are the raw operands; neg=0 and ovf=0 always.
- Outputs Q, R, neg, div0 and ovf hold their value from the last DONE until the next FIX; they change only in FIX.

## Timing

- **Reset values:** busy=0, done=0, Q=0, R=0, neg=0, div0=0, ovf=0; state IDLE.
- **Latency:**
  - start sampled at edge k → busy=1 after edge k.
  - done=1 in the cycle after edge k+WIDTH+1, i.e. WIDTH+2 cycles after start.
  - busy falls in the same cycle that done rises.
- **Throughput:** start may be asserted during the done cycle and is accepted. Back-to-back issue gives one result every WIDTH+2 cycles.
- **start while busy=1:** ignored. No queueing, no effect on the in-flight operation.
- **Input capture:** A and B are sampled only on the accepting edge; later changes are ignored.
- **rst mid-operation:** at the next edge, return to IDLE and clear all outputs. The in-flight result is discarded and no done pulse is generated. rst has priority over start on the same edge.

## Test plan

All scenarios use WIDTH=8, SIGNED=1 unless noted.

- 1 / 10:
  - Q=0, R=1, neg=0, div0=0.
  - done exactly 10 cycles after start; busy high for cycles 1–9.
- -1 (8'hFF) / 10:
  - Q=0, R=8'hFF, neg=0.
  - Then -100 / 7 → Q=8'hF2 (-14), R=8'hFE (-2), neg=1.
  - Then 100 / -7 → Q=-14, R=2, neg=1.
- 5 / 0:
  - div0=1, Q=8'hFF, R=5, ovf=0, done still at 10 cycles.
  - Then -128 / -1 → Q=8'h80, R=0, ovf=1.
- Back-to-back and ignored start:
  - start=1 held continuously with 100/7 then 23/4; results 14 r 2 and 5 r 3 on consecutive done pulses, 10 cycles apart.
  - A pulse of start mid-CALC does not alter the result.
- Reset mid-operation:
  - Assert rst for one edge 4 cycles into 100/7.
  - Required: busy=0 and all outputs 0 next cycle, no done pulse follows.
  - A fresh start then gives 14 r 2.
- Parameter sweep:
  - SIGNED=0, 200/3 → Q=66, R=2, neg=0.
  - WIDTH=16, SIGNED=1, -30000/7 → Q=-4285, R=-5, done at 18 cycles.
